// File: rtl/sym_window_pipe.sv
// Two-stage streaming evaluator: out_hit = popcount(in_data) within [lo, hi], valid/ready flow.
// Optional saturating hit counter enabled by defining SYM_HIT_CNT_EN.
module sym_window_pipe #(
  parameter int unsigned N      = 9,
  parameter int unsigned LO_RST = 3,
  parameter int unsigned HI_RST = 6,
  parameter int unsigned HCW    = 16,
  localparam int unsigned CW    = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_wr,
  input  logic [CW-1:0]  cfg_lo,
  input  logic [CW-1:0]  cfg_hi,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_hit,
  output logic [CW-1:0]  out_count,
  output logic [HCW-1:0] hit_cnt
);

  localparam logic [CW-1:0] LoRst = CW'(LO_RST);
  localparam logic [CW-1:0] HiRst = CW'(HI_RST);

  logic [CW-1:0] win_lo, win_hi;
  logic          s1_valid;
  logic [CW-1:0] s1_count, s1_lo, s1_hi;
  logic [CW-1:0] pop;
  logic          s2_load;
  logic          accept;

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(N); i++) begin
      pop = pop + CW'(in_data[i]);
    end
  end

  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~rst & (~s1_valid | s2_load);
  assign accept   = in_valid & in_ready;

  // Window is snapshotted into S1 with each word, so cfg_wr never affects words already accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_lo <= LoRst;
      win_hi <= HiRst;
    end else if (cfg_wr) begin
      win_lo <= cfg_lo;
      win_hi <= cfg_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_count <= '0;
      s1_lo    <= '0;
      s1_hi    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_count <= pop;
      s1_lo    <= win_lo;
      s1_hi    <= win_hi;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_count <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_count <= s1_count;
      out_hit   <= (s1_count >= s1_lo) && (s1_count <= s1_hi);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SYM_HIT_CNT_EN
  logic [HCW-1:0] hit_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
    end else if (out_valid && out_ready && out_hit && (hit_cnt_q != {HCW{1'b1}})) begin
      hit_cnt_q <= hit_cnt_q + 1'b1;
    end
  end

  assign hit_cnt = hit_cnt_q;
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_sym_window_pipe.sv
// Directed bench for sym_window_pipe: full sweep, backpressure, window changes, reset, hit counter.
module tb_sym_window_pipe;

  localparam int unsigned N   = 9;
  localparam int unsigned CW  = 4;
  localparam int unsigned HCW = 2;
`ifdef SYM_HIT_CNT_EN
  localparam bit HitEn = 1'b1;
`else
  localparam bit HitEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_wr;
  logic [CW-1:0]  cfg_lo, cfg_hi;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_hit;
  logic [CW-1:0]  out_count;
  logic [HCW-1:0] hit_cnt;

  int n_cmp = 0;
  int n_err = 0;

  sym_window_pipe #(.N(N), .LO_RST(3), .HI_RST(6), .HCW(HCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hit   (out_hit),
    .out_count (out_count),
    .hit_cnt   (hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [CW-1:0] lo, input logic [CW-1:0] hi);
    cfg_wr = 1'b1; cfg_lo = lo; cfg_hi = hi;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_wr = 1'b0; cfg_lo = '0; cfg_hi = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready_low got %b want 0", in_ready); end
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_hit !== 1'b0) begin n_err++; $display("FAIL rst_out_hit got %b want 0", out_hit); end
    n_cmp++; if (out_count !== 4'd0) begin n_err++; $display("FAIL rst_out_count got %0d want 0", out_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (hit_cnt !== 2'd0) begin n_err++; $display("FAIL rst_hit_cnt got %0d want 0", hit_cnt); end
  endtask

  task automatic test_stream();
    int cnt;
    logic exp_hit;
    out_ready = 1'b1;
    for (int c = 0; c <= 512; c++) begin
      in_valid = (c < 512);
      in_data  = N'(c);
      #1;
      if (c < 512) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready word %0d got %b want 1", c, in_ready); end
      end
      tick();
      if (c == 0) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency_early got %b want 0", out_valid); end
      end else begin
        cnt = $countones(c - 1);
        exp_hit = (cnt >= 3) && (cnt <= 6);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid word %0d got %b want 1", c - 1, out_valid); end
        n_cmp++; if (out_count !== CW'(cnt)) begin n_err++; $display("FAIL stream_count word %0d got %0d want %0d", c - 1, out_count, cnt); end
        n_cmp++; if (out_hit !== exp_hit) begin n_err++; $display("FAIL stream_hit word %0d got %b want %b", c - 1, out_hit, exp_hit); end
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 9'h1FF;
    tick();
    in_data = 9'h007;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_second_accept got %b want 1", in_ready); end
    tick();
    in_data = 9'h000;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready got %b want 0", in_ready); end
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid got %b want 1", out_valid); end
    n_cmp++; if (out_count !== 4'd9) begin n_err++; $display("FAIL bp_hold_count got %0d want 9", out_count); end
    n_cmp++; if (out_hit !== 1'b0) begin n_err++; $display("FAIL bp_hold_hit got %b want 0", out_hit); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_count, out_hit} !== {1'b1, 4'd3, 1'b1})
      begin n_err++; $display("FAIL bp_second_out got v%b c%0d h%b want v1 c3 h1", out_valid, out_count, out_hit); end
    tick();
    n_cmp++; if ({out_valid, out_count, out_hit} !== {1'b1, 4'd0, 1'b0})
      begin n_err++; $display("FAIL bp_third_out got v%b c%0d h%b want v1 c0 h0", out_valid, out_count, out_hit); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_window_change();
    out_ready = 1'b1;
    cfg_wr = 1'b1; cfg_lo = 4'd0; cfg_hi = 4'd1;
    in_valid = 1'b1; in_data = 9'h001;
    tick();
    cfg_wr = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_count, out_hit} !== {1'b1, 4'd1, 1'b0})
      begin n_err++; $display("FAIL win_old got v%b c%0d h%b want v1 c1 h0", out_valid, out_count, out_hit); end
    tick();
    n_cmp++; if ({out_valid, out_count, out_hit} !== {1'b1, 4'd1, 1'b1})
      begin n_err++; $display("FAIL win_new got v%b c%0d h%b want v1 c1 h1", out_valid, out_count, out_hit); end
    tick();
  endtask

  task automatic test_windows();
    out_ready = 1'b1;
    send_cfg(4'd5, 4'd2);
    in_valid = 1'b1; in_data = 9'h0F8;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if ({out_valid, out_count, out_hit} !== {1'b1, 4'd5, 1'b0})
      begin n_err++; $display("FAIL win_empty got v%b c%0d h%b want v1 c5 h0", out_valid, out_count, out_hit); end
    send_cfg(4'd9, 4'd15);
    in_valid = 1'b1; in_data = 9'h1FF;
    tick();
    in_data = 9'h0FF;
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_count, out_hit} !== {1'b1, 4'd9, 1'b1})
      begin n_err++; $display("FAIL win_unbounded_all got v%b c%0d h%b want v1 c9 h1", out_valid, out_count, out_hit); end
    tick();
    n_cmp++; if ({out_valid, out_count, out_hit} !== {1'b1, 4'd8, 1'b0})
      begin n_err++; $display("FAIL win_unbounded_8 got v%b c%0d h%b want v1 c8 h0", out_valid, out_count, out_hit); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 9'h00F;
    tick();
    in_data = 9'h0F0;
    tick();
    n_cmp++; if ({out_valid, in_ready} !== 2'b10)
      begin n_err++; $display("FAIL rmid_full got v%b r%b want v1 r0", out_valid, in_ready); end
    rst = 1'b1; out_ready = 1'b1; in_data = 9'h1FF;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready_in_rst got %b want 0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01)
      begin n_err++; $display("FAIL rmid_after got v%b r%b want v0 r1", out_valid, in_ready); end
    in_valid = 1'b1; in_data = 9'h007;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale got %b want 0", out_valid); end
    tick();
    n_cmp++; if ({out_valid, out_count, out_hit} !== {1'b1, 4'd3, 1'b1})
      begin n_err++; $display("FAIL rmid_window got v%b c%0d h%b want v1 c3 h1", out_valid, out_count, out_hit); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_drain got %b want 0", out_valid); end
  endtask

  task automatic test_hit_cnt();
    logic [HCW-1:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 9'h007;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (hit_cnt !== 2'd0) begin n_err++; $display("FAIL hc_stalled got %0d want 0", hit_cnt); end
    out_ready = 1'b1;
    tick();
    exp = HitEn ? 2'd1 : 2'd0;
    n_cmp++; if (hit_cnt !== exp) begin n_err++; $display("FAIL hc_first got %0d want %0d", hit_cnt, exp); end
    in_valid = 1'b1;
    tick(); tick(); tick();
    exp = HitEn ? 2'd2 : 2'd0;
    n_cmp++; if (hit_cnt !== exp) begin n_err++; $display("FAIL hc_second got %0d want %0d", hit_cnt, exp); end
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    exp = HitEn ? 2'd3 : 2'd0;
    n_cmp++; if (hit_cnt !== exp) begin n_err++; $display("FAIL hc_saturated got %0d want %0d", hit_cnt, exp); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_window_change();
    test_windows();
    test_reset_mid();
    test_hit_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
